// File: rtl/common_pkg.sv
// Shared definitions for the boot path: datapath width and loader FSM states.
package common;
   localparam int XLEN_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      DATA,
      DONE,
      ERROR
   } loader_state_t;
endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       frame_error
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t     state_q;
   logic          rx_meta_q, rx_sync_q, rx_prev_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          stop_sample;

   // Byte outcome is decoded in the stop-sample cycle so the loader sees it without extra latency.
   assign stop_sample = (state_q == RX_STOP) && (cnt_q == FULL_CNT);
   assign byte_valid  = stop_sample & rx_sync_q;
   assign frame_error = stop_sample & ~rx_sync_q;
   assign data        = shift_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         case (state_q)
            RX_IDLE: begin
               cnt_q <= '0;
               bit_q <= '0;
               if (!rx_sync_q && rx_prev_q) state_q <= RX_START;
            end
            RX_START: begin
               if (cnt_q == HALF_CNT) begin
                  cnt_q   <= '0;
                  state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            RX_DATA: begin
               if (cnt_q == FULL_CNT) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_sync_q, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= RX_STOP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            RX_STOP: begin
               if (cnt_q == FULL_CNT) begin
                  cnt_q   <= '0;
                  state_q <= RX_IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed little-endian image over UART and
// writes it word by word into program memory, holding the core off meanwhile.
module program_loader
   import common::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int MEM_WORDS    = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  uart_rx,
   output logic                  write_enable,
   output logic [XLEN_WIDTH-1:0] write_address,
   output logic [XLEN_WIDTH-1:0] write_data,
   output logic                  loading,
   output logic                  done,
   output logic                  error,
   output logic                  frame_error
);
   localparam int IDXW = $clog2(MEM_WORDS + 1);

   logic [7:0]  rx_data;
   logic        rx_valid;

   loader_state_t         state_q;
   logic [1:0]            byte_cnt_q;
   logic [IDXW-1:0]       word_idx_q;
   logic [23:0]           hdr_q;
   logic [31:0]           n_q;
   logic [23:0]           asm_q;
   logic                  we_q, loading_q, done_q, error_q;
   logic [XLEN_WIDTH-1:0] addr_q, data_q;

   logic [31:0] hdr_d;
   logic [31:0] word_d;
   logic        last_word_d;

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk         (clk),
      .reset       (reset),
      .rx          (uart_rx),
      .data        (rx_data),
      .byte_valid  (rx_valid),
      .frame_error (frame_error)
   );

   // The 4th byte completes a value directly from the receiver, so only 3 bytes are buffered.
   assign hdr_d       = {rx_data, hdr_q};
   assign word_d      = {rx_data, asm_q};
   assign last_word_d = (n_q == 32'(word_idx_q) + 32'd1);

   assign write_enable  = we_q;
   assign write_address = addr_q;
   assign write_data    = data_q;
   assign loading       = loading_q;
   assign done          = done_q;
   assign error         = error_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         byte_cnt_q <= '0;
         word_idx_q <= '0;
         hdr_q      <= '0;
         n_q        <= '0;
         asm_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         loading_q  <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rx_valid) begin
                  hdr_q[7:0] <= rx_data;
                  byte_cnt_q <= 2'd1;
                  state_q    <= HEADER;
               end
            end
            HEADER: begin
               if (rx_valid) begin
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  case (byte_cnt_q)
                     2'd1:    hdr_q[15:8]  <= rx_data;
                     2'd2:    hdr_q[23:16] <= rx_data;
                     default: begin
                        n_q <= hdr_d;
                        if (hdr_d == 32'd0) begin
                           state_q   <= DONE;
                           done_q    <= 1'b1;
                           loading_q <= 1'b0;
                        end else if (hdr_d > 32'(MEM_WORDS)) begin
                           state_q <= ERROR;
                           error_q <= 1'b1;
                        end else begin
                           state_q <= DATA;
                        end
                     end
                  endcase
               end
            end
            DATA: begin
               if (rx_valid) begin
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  case (byte_cnt_q)
                     2'd0:    asm_q[7:0]   <= rx_data;
                     2'd1:    asm_q[15:8]  <= rx_data;
                     2'd2:    asm_q[23:16] <= rx_data;
                     default: begin
                        we_q       <= 1'b1;
                        data_q     <= word_d;
                        addr_q     <= XLEN_WIDTH'({word_idx_q, 2'b00});
                        word_idx_q <= word_idx_q + IDXW'(1);
                        if (last_word_d) begin
                           state_q   <= DONE;
                           done_q    <= 1'b1;
                           loading_q <= 1'b0;
                        end
                     end
                  endcase
               end
            end
            DONE:    ;
            ERROR:   ;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader and writer side of the program memory's write port. It receives a program image over a UART serial line and assembles the bytes into 32-bit little-endian words. Each word is written sequentially into the instruction memory through the `write_enable` / `write_address` / `write_data` port. The processor core is held off via `loading` until the image is complete.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud); must be ≥ 4.
- `MEM_WORDS`, default 256: instruction memory depth in words; maximum accepted image length.

- `clk`  in  1  system clock; the single clock for the block.
- `reset`  in  1  asynchronous, active-high reset.
- `uart_rx`  in  1  serial input, idle high, 8N1, LSB first; asynchronous to `clk`.
- `write_enable`  out  1  one-cycle write strobe to program memory.
- `write_address`  out  XLEN_WIDTH  byte address of the word being written (word index × 4).
- `write_data`  out  XLEN_WIDTH  assembled instruction word.
- `loading`  out  1  high until the image has been fully written; holds the core in reset.
- `done`  out  1  high after a successful load; sticky until `reset`.
- `error`  out  1  high if the header length exceeds `MEM_WORDS`; sticky until `reset`.
- `frame_error`  out  1  one-cycle pulse when a received byte has a low stop bit.

## Operation
- Image format:
  - a 4-byte little-endian header N, the word count;
  - followed by N words, 4 bytes each, little-endian.
  - Word k is written to byte address 4k, k = 0…N-1.
- UART receiver:
  - `uart_rx` passes through a 2-flop synchronizer.
  - A falling edge on the synchronized line starts a bit counter.
  - At CLKS_PER_BIT/2 (integer division) the start bit is re-sampled; if it is high, this is a false start and the receiver returns to idle.
  - Data bits are then sampled every CLKS_PER_BIT cycles, LSB first, followed by the stop bit.
  - Stop bit = 1: one-cycle `byte_valid` pulse with the byte.
  - Stop bit = 0: byte discarded, one-cycle `frame_error` pulse.
- Loader FSM, state type `loader_state_t`:
  - IDLE → HEADER on the first valid byte, which is stored as header byte 0.
  - HEADER: collects 4 bytes. On the 4th byte:
    - N = 0 → DONE;
    - N > MEM_WORDS → ERROR;
    - otherwise → DATA.
  - DATA: shifts bytes into a 32-bit assembly register (byte j goes to bits [8j+7:8j]). On the 4th byte of a word:
    - register the word into `write_data` and the address into `write_address`;
    - pulse `write_enable` for one cycle;
    - increment the word index.
    - After word N-1 is written → DONE.
  - DONE: `loading`=0, `done`=1. Terminal until reset; further bytes are ignored.
  - ERROR: `error`=1, `loading` stays 1, no further writes. Terminal until reset.
- The byte-within-word counter is 2 bits and wraps 3→0.
- The word index is sized to count to MEM_WORDS.
- Header bits above those needed to express MEM_WORDS still participate in the N > MEM_WORDS comparison, so no truncation is allowed.

## Timing
- Reset values:
  - `write_enable`=0, `write_address`=0, `write_data`=0;
  - `loading`=1, `done`=0, `error`=0, `frame_error`=0;
  - FSM = IDLE, receiver idle, all counters 0.
- `byte_valid` asserts in the cycle of the stop-bit sample. `write_enable` asserts the cycle after the `byte_valid` of the 4th byte of each word.
- `write_address` and `write_data` are stable while `write_enable` is high and hold their values afterwards.
- Data-word end: `loading` falls and `done` rises in the same cycle as the final `write_enable`.
- Header end:
  - N = 0 → `done` rises the cycle after the 4th header `byte_valid`;
  - N > MEM_WORDS → `error` rises the cycle after the 4th header `byte_valid`.
- A `frame_error` does not advance any FSM counter; the next good byte continues the current position.
- Reset mid-operation returns to reset values immediately, including mid-byte. A partially received word is never written.
- At most one write every 4 byte times, so no backpressure is needed; program memory accepts a write every cycle.

## Structure
- Shared package `common`:
  - `XLEN_WIDTH` (existing);
  - new `loader_state_t` enum {IDLE, HEADER, DATA, DONE, ERROR}.
- Sub-module `uart_rx`:
  - parameter `CLKS_PER_BIT`;
  - ports `clk`, `reset`, `rx`, `data[7:0]`, `byte_valid`, `frame_error`;
  - contains the synchronizer and the bit-timing FSM.
- `program_loader` contains the header, assembly and write FSM, and instantiates `uart_rx`.

## Test plan
All scenarios run with CLKS_PER_BIT=4 and MEM_WORDS=256.
- N=1, bytes 01 00 00 00 93 00 50 00 → one `write_enable` pulse: address 0x0, data 0x00500093. `done`=1 and `loading`=0 from that cycle.
- N=3, words 0x00000013, 0x00100093, 0xFFFFFFFF → exactly three pulses at addresses 0x0, 0x4, 0x8 with matching data. `done` rises with the third pulse.
- N=0 (00 00 00 00) → no `write_enable`; `done`=1 one cycle after the 4th header `byte_valid`.
- N=257 (01 01 00 00), then 8 more bytes → `error`=1, `loading`=1, no `write_enable`, `done`=0.
- N=1, one data byte sent with stop bit 0, then the correct 4 bytes → one `frame_error` pulse and a single write of the correct word at 0x0.
- Assert `reset` after 2 of 4 data bytes of word 1 (N=2) → all outputs return to reset values and no write of word 1 occurs. A following full image loads correctly from address 0.
